calc_seq_ctrl: RTL and testbench

Key-driven sequencer for the signed 32-bit calculator datapath. It assembles decimal operands and an operator from debounced keypad events and strobes the datapath once per operation. It captures the result and supports chained operations, clear, backspace and sign toggle. It sits between the keypad decoder and the calculator core, and feeds the 7-segment display formatter.

---
 rtl/calc_pkg.sv | 65 ++++++
 rtl/calc_entry.sv | 72 +++++++
 rtl/calc_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, operator
// codes, display sentinels and the sequencer state encoding.
package calc_pkg;

  localparam int CALC_W = 32;

  // Keypad event codes (0..9 are digits, 19..31 are unused)
  localparam logic [4:0] KEY_EQ  = 5'd10;
  localparam logic [4:0] KEY_MUL = 5'd11;
  localparam logic [4:0] KEY_DIV = 5'd12;
  localparam logic [4:0] KEY_ADD = 5'd13;
  localparam logic [4:0] KEY_SUB = 5'd14;
  localparam logic [4:0] KEY_MOD = 5'd15;
  localparam logic [4:0] KEY_CLR = 5'd16;
  localparam logic [4:0] KEY_BS  = 5'd17;
  localparam logic [4:0] KEY_NEG = 5'd18;

  // Operator codes driven to the core
  localparam logic [2:0] OP_NULL = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;

  localparam logic [CALC_W-1:0] CALC_ERR  = 32'h00EE_0000;
  localparam logic [CALC_W-1:0] CALC_NULL = 32'h00CC_0000;

  // Sequencer states
  typedef logic [2:0] calc_state_t;
  localparam calc_state_t ST_ENT1 = 3'd0;
  localparam calc_state_t ST_OPR  = 3'd1;
  localparam calc_state_t ST_ENT2 = 3'd2;
  localparam calc_state_t ST_EXEC = 3'd3;
  localparam calc_state_t ST_WAIT = 3'd4;
  localparam calc_state_t ST_SHOW = 3'd5;
  localparam calc_state_t ST_ERR  = 3'd6;

  // One-hot-ish classification of a qualified key event
  typedef struct packed {
    logic digit;
    logic eq;
    logic op;
    logic clr;
    logic bs;
    logic neg;
  } key_dec_t;

  function automatic key_dec_t key_decode(input logic vld, input logic [4:0] code);
    key_dec_t d;
    d.digit = vld && (code <= 5'd9);
    d.eq    = vld && (code == KEY_EQ);
    d.op    = vld && (code >= KEY_MUL) && (code <= KEY_MOD);
    d.clr   = vld && (code == KEY_CLR);
    d.bs    = vld && (code == KEY_BS);
    d.neg   = vld && (code == KEY_NEG);
    return d;
  endfunction

  // Operator keys 11..15 map directly onto operator codes 1..5
  function automatic logic [2:0] key_to_op(input logic [4:0] code);
    return 3'(code - KEY_EQ);
  endfunction

endpackage

// File: rtl/calc_entry.sv
// Decimal entry accumulator: magnitude, sign flag and digit count, with
// digit append, backspace and negate. Exposes both the registered value and
// the value it will hold after this edge so the display can track it.
module calc_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 6
) (
  input  logic              sw_clk,
  input  logic              rst,
  input  logic              fresh,
  input  logic              dig_en,
  input  logic [3:0]        digit,
  input  logic              bs_en,
  input  logic              neg_en,
  output logic [CALC_W-1:0] value,
  output logic [CALC_W-1:0] value_nxt
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  // Largest magnitude that may still be negated, so a negative entry
  // never needs more than MAX_DIGITS-1 digits.
  localparam logic [CALC_W-1:0] NEG_MAX = CALC_W'(10 ** (MAX_DIGITS - 1) - 1);

  logic [CALC_W-1:0] mag, mag_n, b_mag;
  logic              neg, neg_n, b_neg;
  logic [CNT_W-1:0]  cnt, cnt_n, b_cnt;
  logic              dig_ok;

  // Next entry: optionally restart from zero, then apply at most one key
  always_comb begin
    b_mag  = fresh ? '0   : mag;
    b_neg  = fresh ? 1'b0 : neg;
    b_cnt  = fresh ? '0   : cnt;
    mag_n  = b_mag;
    neg_n  = b_neg;
    cnt_n  = b_cnt;
    dig_ok = (b_cnt != CNT_MAX) && !(b_neg && (b_cnt == CNT_MAX - CNT_W'(1)));
    if (dig_en) begin
      // a leading zero leaves the entry untouched
      if (dig_ok && !((b_mag == '0) && (digit == 4'd0))) begin
        mag_n = b_mag * CALC_W'(10) + CALC_W'(digit);
        cnt_n = b_cnt + CNT_W'(1);
      end
    end else if (bs_en) begin
      if (b_cnt != '0) begin
        mag_n = b_mag / CALC_W'(10);
        cnt_n = b_cnt - CNT_W'(1);
      end
    end else if (neg_en) begin
      if (b_neg || (b_mag <= NEG_MAX)) neg_n = !b_neg;
    end
  end

  // Entry registers
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      mag <= '0;
      neg <= 1'b0;
      cnt <= '0;
    end else begin
      mag <= mag_n;
      neg <= neg_n;
      cnt <= cnt_n;
    end
  end

  assign value     = neg   ? (CALC_W'(0) - mag)   : mag;
  assign value_nxt = neg_n ? (CALC_W'(0) - mag_n) : mag_n;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Key-driven sequencer for the calculator core: builds operands from key
// events, strobes the core once per operation, captures the answer and
// supports chaining, repeat-equals, clear, backspace and negate.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int CALC_LAT   = 2,
  parameter int MAX_DIGITS = 6
) (
  input  logic               sw_clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [4:0]         key_code,
  input  logic [31:0]        ans,
  output logic signed [31:0] operand1,
  output logic signed [31:0] operand2,
  output logic [2:0]         operator,
  output logic               calc_en,
  output logic [31:0]        disp,
  output logic               busy
);

  localparam int LAT_W = $clog2(CALC_LAT + 1) + 1;
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(CALC_LAT);

  calc_state_t        st, st_n;
  logic signed [31:0] op1_n, op2_n;
  logic [2:0]         opr_n, pend, pend_n;
  logic [31:0]        res, res_n, disp_n;
  logic [LAT_W-1:0]   lat, lat_n;
  logic               cen_n;
  key_dec_t           kd;
  logic               ent_fresh, ent_dig, ent_bs, ent_neg;
  logic [31:0]        ent_val, ent_val_n;
  logic               div_zero;

  assign kd       = key_decode(key_valid, key_code);
  assign div_zero = ((operator == OP_DIV) || (operator == OP_MOD)) && (operand2 == 32'sd0);
  assign busy     = (st == ST_EXEC) || (st == ST_WAIT);

  calc_entry #(.MAX_DIGITS(MAX_DIGITS)) u_entry (
    .sw_clk    (sw_clk),
    .rst       (rst),
    .fresh     (ent_fresh),
    .dig_en    (ent_dig),
    .digit     (key_code[3:0]),
    .bs_en     (ent_bs),
    .neg_en    (ent_neg),
    .value     (ent_val),
    .value_nxt (ent_val_n)
  );

  // Sequencer next-state, operand and entry-control decode
  always_comb begin
    st_n      = st;
    op1_n     = operand1;
    op2_n     = operand2;
    opr_n     = operator;
    pend_n    = pend;
    res_n     = res;
    lat_n     = lat;
    cen_n     = 1'b0;
    ent_fresh = 1'b0;
    ent_dig   = 1'b0;
    ent_bs    = 1'b0;
    ent_neg   = 1'b0;
    if (kd.clr) begin
      // clear beats everything, including a WAIT that is about to capture
      st_n      = ST_ENT1;
      op1_n     = '0;
      op2_n     = '0;
      opr_n     = OP_NULL;
      pend_n    = OP_NULL;
      lat_n     = '0;
      ent_fresh = 1'b1;
    end else begin
      case (st)
        ST_ENT1: begin
          ent_dig = kd.digit;
          ent_bs  = kd.bs;
          ent_neg = kd.neg;
          if (kd.op) begin
            op1_n = ent_val;
            opr_n = key_to_op(key_code);
            st_n  = ST_OPR;
          end
        end
        ST_OPR: begin
          if (kd.op) begin
            opr_n = key_to_op(key_code);
          end else if (kd.digit || kd.bs || kd.neg) begin
            ent_fresh = 1'b1;
            ent_dig   = kd.digit;
            ent_bs    = kd.bs;
            ent_neg   = kd.neg;
            st_n      = ST_ENT2;
          end
        end
        ST_ENT2: begin
          ent_dig = kd.digit;
          ent_bs  = kd.bs;
          ent_neg = kd.neg;
          if (kd.op || kd.eq) begin
            op2_n  = ent_val;
            pend_n = kd.op ? key_to_op(key_code) : OP_NULL;
            st_n   = ST_EXEC;
          end
        end
        ST_EXEC: begin
          // a zero divisor never reaches the core
          if (div_zero) begin
            st_n = ST_ERR;
          end else begin
            cen_n = 1'b1;
            lat_n = '0;
            st_n  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat == LAT_END) begin
            res_n = ans;
            if (ans == CALC_ERR) begin
              st_n = ST_ERR;
            end else if (pend == OP_NULL) begin
              st_n = ST_SHOW;
            end else begin
              op1_n = ans;
              opr_n = pend;
              st_n  = ST_OPR;
            end
          end else begin
            lat_n = lat + LAT_W'(1);
          end
        end
        ST_SHOW: begin
          if (kd.op) begin
            op1_n = res;
            opr_n = key_to_op(key_code);
            st_n  = ST_OPR;
          end else if (kd.eq) begin
            // repeat the last operation on the result
            op1_n  = res;
            pend_n = OP_NULL;
            st_n   = ST_EXEC;
          end else if (kd.digit) begin
            ent_fresh = 1'b1;
            ent_dig   = 1'b1;
            st_n      = ST_ENT1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display follows the state being entered; frozen while the core works
  always_comb begin
    case (st_n)
      ST_ENT1, ST_ENT2: disp_n = ent_val_n;
      ST_OPR:           disp_n = op1_n;
      ST_SHOW:          disp_n = res_n;
      ST_ERR:           disp_n = CALC_ERR;
      default:          disp_n = disp;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      st       <= ST_ENT1;
      operand1 <= '0;
      operand2 <= '0;
      operator <= OP_NULL;
      pend     <= OP_NULL;
      res      <= '0;
      lat      <= '0;
      calc_en  <= 1'b0;
      disp     <= '0;
    end else begin
      st       <= st_n;
      operand1 <= op1_n;
      operand2 <= op2_n;
      operator <= opr_n;
      pend     <= pend_n;
      res      <= res_n;
      lat      <= lat_n;
      calc_en  <= cen_n;
      disp     <= disp_n;
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed test-plan sequences plus random key
// streams, checked against an operation-level reference model.
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int CALC_LAT = 2;
  localparam int MAXD     = 6;
  localparam int NEG_LIM  = 10 ** (MAXD - 1) - 1;

  logic               sw_clk = 1'b0;
  logic               rst = 1'b1;
  logic               key_valid = 1'b0;
  logic [4:0]         key_code = '0;
  logic [31:0]        ans;
  logic signed [31:0] operand1, operand2;
  logic [2:0]         operator;
  logic               calc_en;
  logic [31:0]        disp;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sw_clk = ~sw_clk;

  calc_seq_ctrl #(.CALC_LAT(CALC_LAT), .MAX_DIGITS(MAXD)) dut (
    .sw_clk    (sw_clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .ans       (ans),
    .operand1  (operand1),
    .operand2  (operand2),
    .operator  (operator),
    .calc_en   (calc_en),
    .disp      (disp),
    .busy      (busy)
  );

  // Core arithmetic with an 8-digit range check
  function automatic logic [31:0] core_calc(input logic signed [31:0] a,
                                            input logic signed [31:0] b,
                                            input logic [2:0] op);
    longint r;
    case (op)
      3'd1:    r = longint'(a) * longint'(b);
      3'd2:    r = (b == 0) ? 0 : longint'(a) / longint'(b);
      3'd3:    r = longint'(a) + longint'(b);
      3'd4:    r = longint'(a) - longint'(b);
      3'd5:    r = (b == 0) ? 0 : longint'(a) % longint'(b);
      default: r = 0;
    endcase
    if (r > 99_999_999 || r < -99_999_999) return CALC_ERR;
    return 32'(r);
  endfunction

  // Core model: ans is valid only in the single cycle CALC_LAT after the strobe
  logic [CALC_LAT-1:0] core_pipe = '0;
  logic [31:0]         core_res = '0;
  bit                  force99 = 1'b0;
  int                  strobes = 0;
  logic signed [31:0]  s_op1 = '0, s_op2 = '0;
  logic [2:0]          s_opr = '0;
  always @(posedge sw_clk) begin
    core_pipe <= (core_pipe << 1) | CALC_LAT'(calc_en);
    if (calc_en) begin
      strobes  <= strobes + 1;
      s_op1    <= operand1;
      s_op2    <= operand2;
      s_opr    <= operator;
      core_res <= force99 ? 32'd99 : core_calc(operand1, operand2, operator);
    end
  end
  assign ans = core_pipe[CALC_LAT-1] ? core_res : 32'hBAD0_BAD0;

  // Reference model: entry kept as a digit list, operations resolved at once
  typedef enum {M_E1, M_OP, M_E2, M_SHOW, M_ERR} mmode_e;
  mmode_e      mm = M_E1;
  int          dq[$];
  bit          mneg = 1'b0;
  int          mop1 = 0, mop2 = 0, mopr = 0;
  logic [31:0] mres = '0;
  bit          m_exec, m_strobe;
  int          x_op1, x_op2, x_opr;

  function automatic int ent_mag();
    int v = 0;
    foreach (dq[i]) v = v * 10 + dq[i];
    return v;
  endfunction

  function automatic int ent_val();
    return mneg ? -ent_mag() : ent_mag();
  endfunction

  function automatic logic [31:0] m_disp();
    case (mm)
      M_E1, M_E2: return ent_val();
      M_OP:       return mop1;
      M_SHOW:     return mres;
      default:    return CALC_ERR;
    endcase
  endfunction

  task automatic ent_key(input int k);
    if (k <= 9) begin
      if (dq.size() == MAXD) return;
      if (mneg && dq.size() == MAXD - 1) return;
      if (dq.size() == 0 && k == 0) return;
      dq.push_back(k);
    end else if (k == 17) begin
      if (dq.size() > 0) void'(dq.pop_back());
    end else if (k == 18) begin
      if (mneg || ent_mag() <= NEG_LIM) mneg = !mneg;
    end
  endtask

  task automatic do_exec(input int pend);
    logic [31:0] r;
    m_exec = 1'b1;
    x_op1 = mop1; x_op2 = mop2; x_opr = mopr;
    if ((mopr == 2 || mopr == 5) && mop2 == 0) begin
      m_strobe = 1'b0;
      mm = M_ERR;
      return;
    end
    m_strobe = 1'b1;
    r = core_calc(mop1, mop2, 3'(mopr));
    mres = r;
    if (r == CALC_ERR) mm = M_ERR;
    else if (pend == 0) mm = M_SHOW;
    else begin mop1 = r; mopr = pend; mm = M_OP; end
  endtask

  task automatic model_key(input int k);
    m_exec = 1'b0; m_strobe = 1'b0;
    if (k == 16) begin
      mm = M_E1; dq.delete(); mneg = 1'b0; mop1 = 0; mop2 = 0; mopr = 0;
      return;
    end
    if (k > 18) return;
    case (mm)
      M_E1:
        if (k >= 11 && k <= 15) begin mop1 = ent_val(); mopr = k - 10; mm = M_OP; end
        else if (k != 10) ent_key(k);
      M_E2:
        if (k >= 10 && k <= 15) begin mop2 = ent_val(); do_exec(k == 10 ? 0 : k - 10); end
        else ent_key(k);
      M_OP:
        if (k >= 11 && k <= 15) mopr = k - 10;
        else if (k != 10) begin dq.delete(); mneg = 1'b0; ent_key(k); mm = M_E2; end
      M_SHOW:
        if (k >= 11 && k <= 15) begin mop1 = mres; mopr = k - 10; mm = M_OP; end
        else if (k == 10) begin mop1 = mres; do_exec(0); end
        else if (k <= 9) begin dq.delete(); mneg = 1'b0; ent_key(k); mm = M_E1; end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one key event from a negedge; returns at the following negedge
  task automatic press_raw(input int k);
    key_valid = 1'b1;
    key_code  = 5'(k);
    @(posedge sw_clk);
    @(negedge sw_clk);
    key_valid = 1'b0;
  endtask

  // Press a key, let any operation complete, then compare against the model
  task automatic press(input int k);
    int s0, nb;
    s0 = strobes;
    press_raw(k);
    model_key(k);
    if (m_exec) begin
      chk("busy_exec", busy, 1'b1);
      nb = 0;
      while (busy === 1'b1 && nb < 40) begin nb++; @(negedge sw_clk); end
      chk("busy_len", 32'(nb), m_strobe ? 32'(CALC_LAT + 2) : 32'd1);
      chk("strobes", 32'(strobes - s0), m_strobe ? 32'd1 : 32'd0);
      if (m_strobe) begin
        chk("x_op1", s_op1, x_op1);
        chk("x_op2", s_op2, x_op2);
        chk("x_opr", 32'(s_opr), x_opr);
      end
    end
    chk("disp", disp, m_disp());
    chk("busy", 32'(busy), 0);
    chk("calc_en", 32'(calc_en), 0);
    chk("op1", operand1, mop1);
    chk("op2", operand2, mop2);
    chk("opr", 32'(operator), mopr);
  endtask

  initial begin
    int s0, r;
    // reset with a coincident key: reset wins
    key_valid = 1'b1;
    key_code  = 5'd5;
    repeat (3) @(negedge sw_clk);
    chk("rst_disp", disp, 0);
    chk("rst_cen", 32'(calc_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op1", operand1, 0);
    chk("rst_opr", 32'(operator), 0);
    rst = 1'b0;
    key_valid = 1'b0;
    @(negedge sw_clk);
    chk("post_rst_disp", disp, 0);

    // 12 + 3 =
    press(1); press(2); press(13); press(3); press(10);
    chk("tp1_op1", s_op1, 12);
    chk("tp1_op2", s_op2, 3);
    chk("tp1_opr", 32'(s_opr), 3);
    chk("tp1_disp", disp, 15);

    // -7 * 6 = then repeat
    press(16); press(7); press(18); press(11);
    chk("tp2_op1", operand1, -7);
    press(6); press(10);
    chk("tp2_disp", disp, -42);
    press(10);
    chk("tp2_rep", disp, -252);

    // divide by zero
    press(16); press(8); press(12); press(0); press(10);
    chk("tp3_err", disp, CALC_ERR);
    press(4);
    chk("tp3_ign", disp, CALC_ERR);
    press(16);
    chk("tp3_clr", disp, 0);

    // digit limit, backspace, negate limits
    for (int d = 1; d <= 7; d++) press(d);
    chk("tp4_max", disp, 123456);
    press(18);
    chk("tp4_negign", disp, 123456);
    press(17);
    chk("tp4_bs", disp, 12345);
    press(18);
    chk("tp4_neg", disp, -12345);
    press(8);
    chk("tp4_negfull", disp, -12345);

    // chained operator executes the pending expression
    press(16); press(9); press(14); press(4); press(11);
    chk("tp5_mid", disp, 5);
    chk("tp5_opr", 32'(operator), 1);
    press(2); press(10);
    chk("tp5_end", disp, 10);

    // clear in the middle of WAIT, and on the capture cycle
    for (int t = 0; t < 2; t++) begin
      press(16); press(5); press(13); press(4);
      force99 = 1'b1;
      s0 = strobes;
      press_raw(10);
      if (t == 0) @(negedge sw_clk);
      else repeat (CALC_LAT + 1) @(negedge sw_clk);
      press_raw(16);
      model_key(16);
      chk("cw_disp", disp, 0);
      chk("cw_busy", 32'(busy), 0);
      for (int i = 0; i < CALC_LAT + 3; i++) begin
        @(negedge sw_clk);
        chk("cw_hold", disp, 0);
      end
      chk("cw_strobes", 32'(strobes - s0), 1);
      force99 = 1'b0;
    end

    // random key streams
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      press($urandom_range(0, 9));
      else if (r < 62) press($urandom_range(11, 15));
      else if (r < 72) press(10);
      else if (r < 79) press(17);
      else if (r < 86) press(18);
      else if (r < 91) press(16);
      else             press($urandom_range(19, 31));
      repeat ($urandom_range(0, 1)) @(negedge sw_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
